// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
// Packs decoded RV32I fields (opcode, register indices, funct3/funct7,
// immediate) into 32-bit machine words and writes them sequentially into an
// instruction memory through a one-cycle write strobe.
// Optional feature: define RV32I_ENC_CHECKSUM_EN to add a running XOR
// checksum of every written word on the checksum output.
module rv32i_instr_encoder #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  input  logic                     finish,
  input  logic                     restart,
  output logic                     wr_en,
  output logic [31:0]              wr_addr,
  output logic [31:0]              wr_data,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     done,
  output logic                     illegal
`ifdef RV32I_ENC_CHECKSUM_EN
  ,
  output logic [31:0]              checksum
`endif
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  // RV32I base opcodes handled by the encoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_reg;

  // Field set captured at the handshake so the source may move on immediately
  logic [6:0]  op_reg;
  logic [4:0]  rd_reg;
  logic [4:0]  rs1_reg;
  logic [4:0]  rs2_reg;
  logic [2:0]  funct3_reg;
  logic [6:0]  funct7_reg;
  logic [31:0] imm_reg;

  logic [31:0] word_next;
  logic        legal_next;
  logic [CW-1:0] count_inc;

  assign count_inc = word_count + 1'b1;

  // Accept only while idle and the target memory still has room
  assign in_ready = (state_reg == IDLE) && (word_count < DEPTH_C);

  // Instruction word formation from the latched fields, selected by format
  always_comb begin
    legal_next = 1'b1;
    word_next  = wr_data;
    case (op_reg)
      OP_R: begin
        word_next = {funct7_reg, rs2_reg, rs1_reg, funct3_reg, rd_reg, op_reg};
      end
      OP_IMM: begin
        // slli/srli/srai carry funct7 above a 5-bit shift amount
        if (funct3_reg == 3'b001 || funct3_reg == 3'b101) begin
          word_next = {funct7_reg, imm_reg[4:0], rs1_reg, funct3_reg, rd_reg, op_reg};
        end else begin
          word_next = {imm_reg[11:0], rs1_reg, funct3_reg, rd_reg, op_reg};
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        word_next = {imm_reg[11:0], rs1_reg, funct3_reg, rd_reg, op_reg};
      end
      OP_STORE: begin
        word_next = {imm_reg[11:5], rs2_reg, rs1_reg, funct3_reg, imm_reg[4:0], op_reg};
      end
      OP_BRANCH: begin
        // imm[0] is implicitly zero for branch offsets and is dropped
        word_next = {imm_reg[12], imm_reg[10:5], rs2_reg, rs1_reg, funct3_reg,
                     imm_reg[4:1], imm_reg[11], op_reg};
      end
      OP_LUI, OP_AUIPC: begin
        word_next = {imm_reg[31:12], rd_reg, op_reg};
      end
      OP_JAL: begin
        word_next = {imm_reg[20], imm_reg[10:1], imm_reg[11], imm_reg[19:12],
                     rd_reg, op_reg};
      end
      default: begin
        legal_next = 1'b0;
      end
    endcase
  end

  // Control FSM with registered write port, status and field capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= 32'h0;
      word_count <= '0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      op_reg     <= 7'h0;
      rd_reg     <= 5'h0;
      rs1_reg    <= 5'h0;
      rs2_reg    <= 5'h0;
      funct3_reg <= 3'h0;
      funct7_reg <= 7'h0;
      imm_reg    <= 32'h0;
`ifdef RV32I_ENC_CHECKSUM_EN
      checksum   <= 32'h0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          // A handshake takes priority over a simultaneous finish request
          if (in_valid && in_ready) begin
            op_reg     <= in_op;
            rd_reg     <= in_rd;
            rs1_reg    <= in_rs1;
            rs2_reg    <= in_rs2;
            funct3_reg <= in_funct3;
            funct7_reg <= in_funct7;
            imm_reg    <= in_imm;
            state_reg  <= ENCODE;
          end else if (finish) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        ENCODE: begin
          if (legal_next) begin
            wr_data   <= word_next;
            wr_en     <= 1'b1;
            state_reg <= WRITE;
          end else begin
            // Unsupported opcode: flag it and drop the field set
            illegal   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        WRITE: begin
          wr_en      <= 1'b0;
          wr_addr    <= wr_addr + 32'd4;
          word_count <= count_inc;
`ifdef RV32I_ENC_CHECKSUM_EN
          checksum   <= checksum ^ wr_data;
`endif
          if (count_inc == DEPTH_C) begin
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= IDLE;
          end
        end
        DONE: begin
          if (restart) begin
            wr_addr    <= BASE_ADDR;
            word_count <= '0;
            done       <= 1'b0;
            illegal    <= 1'b0;
`ifdef RV32I_ENC_CHECKSUM_EN
            checksum   <= 32'h0;
`endif
            state_reg  <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
